// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Multi-cycle adder/subtractor. A WIDTH-bit operation is split into
// N = WIDTH/SLICE slices. One slice is processed per clock, least significant
// slice first. The carry between slices is held in a register.
//
//   sub = 0 : s = a + b + ci
//   sub = 1 : s = a - b, computed as a + ~b + 1 (ci is ignored)
//
// Handshake (start / busy / done):
//   - start is sampled only while IDLE. At that edge the design latches
//     a, b, sub and ci, and busy rises.
//   - busy stays high for the N RUN cycles.
//   - done pulses for exactly one cycle (the FIN state). s/co/ov are
//     updated on that same edge.
//   - start seen during RUN or FIN is dropped, not queued. The next start
//     can therefore be accepted N+2 edges after the previous one.
//   - s/co/ov are only written at completion, so they never show a
//     partial result.
//
// Ports:
//   clk        clock; all state changes happen on the rising edge
//   rst_n      synchronous, active-low reset; aborts any operation
//   start      request a new operation
//   sub        0 = add, 1 = subtract
//   a, b       WIDTH-bit operands
//   ci         carry-in (add mode only)
//   busy       operation in progress (RUN state)
//   done       one-cycle completion pulse
//   s          WIDTH-bit result
//   co         carry out of the MSB (in subtract mode: 1 = no borrow)
//   ov         signed overflow (carry into MSB xor carry out of MSB)
//   state_dbg  current FSM state encoding (IDLE=0, RUN=1, FIN=2)
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov,
    output logic [1:0]       state_dbg
);

    // Refuse to build a configuration that cannot be sliced evenly.
    generate
        if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_param_check
            $error("serial_adder: WIDTH must be >= 1 and an exact multiple of SLICE");
        end
    endgenerate

    localparam int N  = WIDTH / SLICE;
    // Keep at least one counter bit, even when the whole word fits in one slice.
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             sub_q;
    logic             carry;
    logic [CW-1:0]    cnt;

    // Datapath for the slice selected by cnt
    int               lsb;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] sum_sl;
    logic             carry_nx;
    logic             msb_cin;
    logic             last;
    logic [WIDTH-1:0] res_nx;

    always_comb begin
        lsb  = int'(cnt) * SLICE;
        a_sl = op_a[lsb +: SLICE];
        // In subtract mode the B slice is inverted. The +1 comes from the
        // carry register, which was preset to 1 when the operation started.
        b_sl = sub_q ? ~op_b[lsb +: SLICE] : op_b[lsb +: SLICE];
        {carry_nx, sum_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry};
        // Recover the carry into the top bit of this slice from that bit's
        // inputs and its sum bit. This is only used on the final slice, where
        // the top bit is the word MSB.
        msb_cin = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ sum_sl[SLICE-1];
        last    = (cnt == CW'(N - 1));
        res_nx  = res;
        res_nx[lsb +: SLICE] = sum_sl;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            sub_q <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            co    <= 1'b0;
            ov    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        sub_q <= sub;
                        carry <= sub ? 1'b1 : ci;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    res   <= res_nx;
                    carry <= carry_nx;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        // Publish the complete word together with its flags.
                        s     <= res_nx;
                        co    <= carry_nx;
                        ov    <= msb_cin ^ carry_nx;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= FIN;
                    end
                end

                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the single-bit full adder.
- Processes WIDTH-bit operands SLICE bits per clock, LSB slice first, through a registered carry chain.
- Supports add or subtract mode, carry-in, carry-out and signed overflow, with a start/busy/done handshake.
- Sits wherever area matters more than latency (e.g. accumulators, address stepping).

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥1.
- SLICE, 1, bits processed per RUN cycle; must be ≥1 and divide WIDTH exactly.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST_N  input  1  synchronous, active-low reset.
- START  input  1  request a new operation; sampled only in IDLE.
- SUB  input  1  0 = A+B+CI; 1 = A-B (computed as A+~B+1; CI ignored).
- A  input  WIDTH  operand A; latched when START is accepted.
- B  input  WIDTH  operand B; latched when START is accepted.
- CI  input  1  carry-in for add mode; latched when START is accepted.
- BUSY  output  1  high while an operation is in progress (RUN state).
- DONE  output  1  one-cycle pulse; S/CO/OV are valid from this cycle.
- S  output  WIDTH  result sum/difference.
- CO  output  1  carry out of MSB; in SUB mode 1 = no borrow, 0 = borrow.
- OV  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (RST_N=0 at a rising edge):
  - state = IDLE; BUSY, DONE, S, CO and OV all = 0.
  - Internal operand/carry/slice-counter registers are cleared.
  - Reset asserted mid-operation aborts the operation; no DONE is produced.
- States: IDLE, RUN, FIN.
- IDLE:
  - START=1 at an edge → latch A, B, SUB.
  - Carry register = SUB ? 1 : CI; slice counter = 0; go to RUN; BUSY=1.
  - START=0 → stay in IDLE.
- RUN, each edge:
  - Add slice [k*SLICE +: SLICE] of A and (SUB ? ~B : B) plus the carry register.
  - Write the slice sum into the internal result register; update the carry register; k++.
  - On the edge that processes slice N-1 (N = WIDTH/SLICE):
    - Go to FIN.
    - Copy the internal result to S.
    - CO = final carry; OV = carry into MSB XOR final carry.
    - DONE=1, BUSY=0.
- FIN: lasts exactly one cycle, then returns to IDLE; DONE=0.
- Latency: START sampled at edge 0 → DONE=1 after edge N. N=8 for defaults; N=1 when SLICE=WIDTH.
- START during RUN or FIN is ignored (not queued). The earliest back-to-back START is sampled in the first IDLE cycle, N+2 edges after the previous start.
- A, B, CI and SUB may change freely after acceptance without affecting the operation in progress.
- S, CO and OV hold their last values from FIN until the next completion. They never expose partial results.
- Arithmetic is modulo 2^WIDTH; there is no saturation.
- The WIDTH/SLICE divisibility violation is rejected at elaboration (generate-time error).

Test Plan:
- WIDTH=8, SLICE=1, SUB=0: A=0x0F, B=0x01, CI=0, START pulse → BUSY high 8 cycles; DONE pulse on 8th edge after start; S=0x10, CO=0, OV=0.
- Add overflow: A=0x7F, B=0x01, CI=0 → S=0x80, CO=0, OV=1. Then A=0xFF, B=0x00, CI=1 → S=0x00, CO=1, OV=0.
- Subtract: SUB=1, A=0x05, B=0x07, CI=1 (must be ignored) → S=0xFE, CO=0, OV=0. Then SUB=1, A=0x80, B=0x01 → S=0x7F, CO=1, OV=1.
- Slicing: WIDTH=16, SLICE=4: A=0x1234, B=0xEDCC, CI=0 → DONE on 4th edge; S=0x0000, CO=1, OV=0. Repeat with SLICE=16 → DONE on 1st edge, same result.
- Handshake:
  - Hold START=1 continuously with changing operands; only operands present in IDLE cycles are used.
  - Back-to-back operations are spaced N+2 cycles apart.
  - S stays at the old value until each DONE.
- Reset mid-op: START with A=0xAA, B=0x55; drive RST_N=0 at edge 3 → S=0, CO=0, OV=0, BUSY=0, and no DONE. Release reset, START with A=0x01, B=0x01 → S=0x02 after 8 edges.
